// File: rtl/day45_req_sequencer_if.sv
// Handshake bundle between the request sequencer, its requesters, the attached
// fixed-priority arbiter and the downstream service consumer.
interface day45_req_sequencer_if #(
   parameter int NUM_PORTS = 16
);
   localparam int ID_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0] req_pulse_i;
   logic [NUM_PORTS-1:0] arb_req_o;
   logic [NUM_PORTS-1:0] arb_gnt_i;
   logic                 svc_valid_o;
   logic [ID_W-1:0]      svc_id_o;
   logic                 svc_ready_i;
   logic                 busy_o;
   logic [NUM_PORTS-1:0] done_o;

   // The sequencer itself.
   modport slave (
      input  req_pulse_i, arb_gnt_i, svc_ready_i,
      output arb_req_o, svc_valid_o, svc_id_o, busy_o, done_o
   );

   // The surroundings: requesters, arbiter and service consumer.
   modport master (
      output req_pulse_i, arb_gnt_i, svc_ready_i,
      input  arb_req_o, svc_valid_o, svc_id_o, busy_o, done_o
   );
endinterface

// File: rtl/day45_req_sequencer.sv
// Collects sticky port requests, hands them to an external fixed-priority arbiter,
// issues the winner downstream and runs a fixed-length service window per grant.
module day45_req_sequencer #(
   parameter int NUM_PORTS  = 16,
   parameter int SVC_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   day45_req_sequencer_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_PORTS);
   localparam int CNT_W = $clog2(SVC_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, SERVICE, DONE} state_t;

   state_t               state_q;
   logic [NUM_PORTS-1:0] pending_q, pending_d;
   logic [NUM_PORTS-1:0] cur_q;
   logic [NUM_PORTS-1:0] done_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 gnt_ok;

   function automatic logic [ID_W-1:0] encode(input logic [NUM_PORTS-1:0] oh);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (oh[i]) id = id | ID_W'(i);
      end
      return id;
   endfunction

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      // done_q is non-zero only in DONE, where it equals cur_q; a strobe in that same cycle survives the clear.
      pending_d = (pending_q & ~done_q) | bus.req_pulse_i;
      gnt_ok    = (bus.arb_gnt_i != '0)
               && ((bus.arb_gnt_i & (bus.arb_gnt_i - NUM_PORTS'(1))) == '0)
               && ((bus.arb_gnt_i & ~pending_q) == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cur_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_ok) begin
                  cur_q   <= bus.arb_gnt_i;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (valid_q && bus.svc_ready_i) begin
                  cnt_q   <= CNT_W'(SVC_CYCLES - 1);
                  valid_q <= 1'b0;
                  state_q <= SERVICE;
               end
            end
            SERVICE: begin
               if (cnt_q == '0) begin
                  done_q  <= cur_q;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               done_q  <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The arbiter only sees requests while no transaction is in flight.
   assign bus.arb_req_o   = (state_q == IDLE) ? pending_q : '0;
   assign bus.svc_valid_o = valid_q;
   assign bus.svc_id_o    = valid_q ? encode(cur_q) : '0;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
endmodule
